// File: rtl/sys_ctrl.sv
// UART command sequencer: parses RX byte frames, drives the register file and ALU,
// and returns read data / ALU results to the UART transmitter.
module sys_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                rf_wr_en,
    output logic                rf_rd_en,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_wr_data,
    input  logic [DATA_W-1:0]   rf_rd_data,
    input  logic                rf_rd_valid,
    output logic                alu_en,
    output logic [3:0]          alu_fun,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                alu_out_valid,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] CMD_WR   = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD   = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU  = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_RUN  = DATA_W'(8'hDD);
    localparam logic [3:0]        FUN_BAD  = 4'hF;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_B0, TX_B1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic                rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
    logic                alu_en_q, alu_en_d;
    logic [3:0]          alu_fun_q, alu_fun_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]   tx_hi_q, tx_hi_d;
    logic                two_q, two_d;
    logic                err_q, err_d;
    logic                timed;

    // States in which the sequencer is waiting on the host for the next frame byte.
    assign timed = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                   (state_q == ALU_A)   || (state_q == ALU_B)   || (state_q == ALU_FUN);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = '0;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        err_d        = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        tx_hi_d      = tx_hi_q;
        two_d        = two_q;

        // A byte arriving in the same cycle as expiry takes priority over the abort.
        if (timed && !rx_valid) begin
            if (cnt_q == CNT_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: if (rx_valid) begin
                if      (rx_data == CMD_WR)  state_d = WR_ADDR;
                else if (rx_data == CMD_RD)  state_d = RD_ADDR;
                else if (rx_data == CMD_ALU) state_d = ALU_A;
                else if (rx_data == CMD_RUN) state_d = ALU_FUN;
                else                         err_d   = 1'b1;
            end
            WR_ADDR: if (rx_valid) begin
                rf_addr_d = rx_data[ADDR_W-1:0];
                state_d   = WR_DATA;
            end
            WR_DATA: if (rx_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_wr_data_d = rx_data;
                state_d      = IDLE;
            end
            RD_ADDR: if (rx_valid) begin
                rf_rd_en_d = 1'b1;
                rf_addr_d  = rx_data[ADDR_W-1:0];
                state_d    = RD_WAIT;
            end
            RD_WAIT: if (rf_rd_valid) begin
                tx_data_d  = rf_rd_data;
                two_d      = 1'b0;
                tx_valid_d = 1'b1;
                state_d    = TX_B0;
            end
            ALU_A, ALU_B: if (rx_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_addr_d    = (state_q == ALU_A) ? ADDR_W'(0) : ADDR_W'(1);
                rf_wr_data_d = rx_data;
                state_d      = (state_q == ALU_A) ? ALU_B : ALU_FUN;
            end
            ALU_FUN: if (rx_valid) begin
                if (rx_data[3:0] == FUN_BAD) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = rx_data[3:0];
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: if (alu_out_valid) begin
                tx_data_d  = alu_out[DATA_W-1:0];
                tx_hi_d    = alu_out[2*DATA_W-1:DATA_W];
                two_d      = 1'b1;
                tx_valid_d = 1'b1;
                state_d    = TX_B0;
            end
            TX_B0: if (tx_ready) begin
                if (two_q) begin
                    tx_data_d = tx_hi_q;
                    state_d   = TX_B1;
                end else begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            TX_B1: if (tx_ready) begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_hi_q      <= '0;
            two_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_hi_q      <= tx_hi_d;
            two_q        <= two_d;
            err_q        <= err_d;
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign alu_en     = alu_en_q;
    assign alu_fun    = alu_fun_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed testbench for sys_ctrl: drives command frames and checks strobes,
// TX handshake, error pulses and timeout against hand-computed values.
module tb_sys_ctrl;

    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rf_wr_en, rf_rd_en, alu_en, tx_valid, err;
    logic [3:0]  rf_addr, alu_fun;
    logic [7:0]  rf_wr_data, tx_data;
    logic [7:0]  rf_rd_data = '0;
    logic        rf_rd_valid = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_out_valid = 1'b0;
    logic        tx_ready = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse counters and an RF model, sampled on the falling edge.
    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, txv_cyc = 0, acc_cnt = 0;
    logic [7:0] rf_m [16];
    logic [7:0] txq [$];

    sys_ctrl #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) rf_m[i] = '0;

    always @(negedge clk) begin
        if (rf_wr_en) begin
            wr_cnt++;
            rf_m[rf_addr] = rf_wr_data;
        end
        if (rf_rd_en) rd_cnt++;
        if (alu_en) alu_cnt++;
        if (err) err_cnt++;
        if (tx_valid) txv_cyc++;
        if (tx_valid && tx_ready) acc_cnt++;
    end

    // Called at posedge+1: presents a byte for exactly one edge, returns at next posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        rf_rd_data  = d;
        rf_rd_valid = 1'b1;
        @(posedge clk); #1;
        rf_rd_valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] r);
        alu_out       = r;
        alu_out_valid = 1'b1;
        @(posedge clk); #1;
        alu_out_valid = 1'b0;
    endtask

    // Accepts n bytes with tx_ready held high; checks tx_valid drops the cycle after the last.
    task automatic collect_tx(input int n, input string name);
        int budget;
        txq.delete();
        tx_ready = 1'b1;
        budget = 0;
        while (txq.size() < n && budget < 20) begin
            @(negedge clk);
            if (tx_valid) txq.push_back(tx_data);
            budget++;
        end
        n_assert++;
        if (txq.size() != n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d bytes, expected %0d", name, txq.size(), n);
        end
        @(negedge clk);
        n_assert++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_valid_fall: tx_valid=%b, expected 0", name, tx_valid);
        end
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        cycles(2);
        n_assert++;
        if ({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_data, tx_valid, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected all 0",
                     {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_data, tx_valid, err});
        end
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_write;
        int w0 = wr_cnt, t0 = txv_cyc;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        n_assert++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h5, 8'h3C}) begin
            n_fail++;
            $display("FAIL wr_strobe: en=%b addr=%h data=%h, expected 1 5 3c", rf_wr_en, rf_addr, rf_wr_data);
        end
        cycles(1);
        n_assert++;
        if (rf_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL wr_one_cycle: rf_wr_en=%b, expected 0", rf_wr_en);
        end
        cycles(5);
        n_assert++;
        if (wr_cnt != w0 + 1 || rf_m[5] !== 8'h3C || txv_cyc != t0) begin
            n_fail++;
            $display("FAIL wr_effect: writes=%0d rf5=%h txcyc=%0d, expected %0d 3c %0d", wr_cnt - w0, rf_m[5], txv_cyc, 1, t0);
        end
    endtask

    task automatic test_read_hold;
        int r0 = rd_cnt, e0 = err_cnt, a0 = acc_cnt;
        send_byte(8'hBB); send_byte(8'h05);
        n_assert++;
        if ({rf_rd_en, rf_addr} !== {1'b1, 4'h5}) begin
            n_fail++; $display("FAIL rd_strobe: en=%b addr=%h, expected 1 5", rf_rd_en, rf_addr);
        end
        send_byte(8'hBB);  // arrives in RD_WAIT: must be dropped silently
        n_assert++;
        if (rf_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL rd_one_cycle: rf_rd_en=%b, expected 0", rf_rd_en);
        end
        pulse_rd(8'h3C);
        n_assert++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h3C}) begin
            n_fail++; $display("FAIL rd_tx_rise: valid=%b data=%h, expected 1 3c", tx_valid, tx_data);
        end
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            n_assert++;
            if ({tx_valid, tx_data} !== {1'b1, 8'h3C}) begin
                n_fail++; $display("FAIL rd_tx_hold%0d: valid=%b data=%h, expected 1 3c", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        cycles(1);
        tx_ready = 1'b0;
        n_assert++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_tx_fall: tx_valid=%b, expected 0", tx_valid);
        end
        cycles(2);
        n_assert++;
        if (acc_cnt != a0 + 1 || rd_cnt != r0 + 1 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL rd_counts: acc=%0d rd=%0d err=%0d, expected 1 1 0", acc_cnt - a0, rd_cnt - r0, err_cnt - e0);
        end
    endtask

    task automatic test_alu_cc;
        send_byte(8'hCC); send_byte(8'h12);
        n_assert++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h0, 8'h12}) begin
            n_fail++; $display("FAIL cc_wr_a: en=%b addr=%h data=%h, expected 1 0 12", rf_wr_en, rf_addr, rf_wr_data);
        end
        send_byte(8'h34);
        n_assert++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h1, 8'h34}) begin
            n_fail++; $display("FAIL cc_wr_b: en=%b addr=%h data=%h, expected 1 1 34", rf_wr_en, rf_addr, rf_wr_data);
        end
        send_byte(8'h02);
        n_assert++;
        if ({alu_en, alu_fun, rf_wr_en} !== {1'b1, 4'h2, 1'b0}) begin
            n_fail++; $display("FAIL cc_alu_en: en=%b fun=%h wr=%b, expected 1 2 0", alu_en, alu_fun, rf_wr_en);
        end
        cycles(2);
        n_assert++;
        if (alu_en !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL cc_wait: alu_en=%b tx_valid=%b, expected 0 0", alu_en, tx_valid);
        end
        pulse_alu(16'h03A8);
        n_assert++;
        if ({tx_valid, tx_data} !== {1'b1, 8'hA8}) begin
            n_fail++; $display("FAIL cc_tx_rise: valid=%b data=%h, expected 1 a8", tx_valid, tx_data);
        end
        collect_tx(2, "cc_tx");
        n_assert++;
        if (txq.size() != 2 || txq[0] !== 8'hA8 || txq[1] !== 8'h03 || rf_m[0] !== 8'h12 || rf_m[1] !== 8'h34 || alu_fun !== 4'h2) begin
            n_fail++;
            $display("FAIL cc_result: bytes=%p rf0=%h rf1=%h fun=%h, expected a8,03 12 34 2", txq, rf_m[0], rf_m[1], alu_fun);
        end
    endtask

    task automatic test_bad_fun;
        int u0 = alu_cnt;
        send_byte(8'hDD); send_byte(8'h0F);
        n_assert++;
        if ({err, alu_en} !== {1'b1, 1'b0}) begin
            n_fail++; $display("FAIL bad_fun: err=%b alu_en=%b, expected 1 0", err, alu_en);
        end
        cycles(1);
        n_assert++;
        if (err !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL bad_fun_pulse: err=%b tx_valid=%b, expected 0 0", err, tx_valid);
        end
        send_byte(8'hDD); send_byte(8'hF0);  // upper nibble ignored: fun = 0
        n_assert++;
        if ({alu_en, alu_fun, err} !== {1'b1, 4'h0, 1'b0}) begin
            n_fail++; $display("FAIL dd_alu_en: en=%b fun=%h err=%b, expected 1 0 0", alu_en, alu_fun, err);
        end
        pulse_alu(16'h0046);
        collect_tx(2, "dd_tx");
        n_assert++;
        if (txq.size() != 2 || txq[0] !== 8'h46 || txq[1] !== 8'h00 || alu_cnt != u0 + 1) begin
            n_fail++; $display("FAIL dd_result: bytes=%p alu_starts=%0d, expected 46,00 1", txq, alu_cnt - u0);
        end
    endtask

    task automatic test_timeout;
        int w0 = wr_cnt, e0 = err_cnt, r0 = rd_cnt, u0 = alu_cnt;
        send_byte(8'hAA); send_byte(8'h05);
        cycles(TIMEOUT - 1);
        n_assert++;
        if (err_cnt != e0 || err !== 1'b0) begin
            n_fail++; $display("FAIL to_early: err pulses=%0d err=%b, expected 0 0", err_cnt - e0, err);
        end
        cycles(1);
        n_assert++;
        if (err !== 1'b1 || rf_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL to_expire: err=%b wr=%b, expected 1 0", err, rf_wr_en);
        end
        cycles(3);
        send_byte(8'h77);
        n_assert++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL bad_cmd: err=%b, expected 1", err);
        end
        cycles(3);
        n_assert++;
        if (wr_cnt != w0 || rd_cnt != r0 || alu_cnt != u0 || err_cnt != e0 + 2) begin
            n_fail++;
            $display("FAIL to_counts: wr=%0d rd=%0d alu=%0d err=%0d, expected 0 0 0 2", wr_cnt - w0, rd_cnt - r0, alu_cnt - u0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid;
        send_byte(8'hDD); send_byte(8'h01);
        cycles(1);
        pulse_alu(16'hBEEF);
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if ({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_data, tx_valid, err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b, expected all 0",
                     {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_data, tx_valid, err});
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        send_byte(8'hBB); send_byte(8'h01);
        n_assert++;
        if ({rf_rd_en, rf_addr} !== {1'b1, 4'h1}) begin
            n_fail++; $display("FAIL post_reset_rd: en=%b addr=%h, expected 1 1", rf_rd_en, rf_addr);
        end
        cycles(1);
        pulse_rd(rf_m[1]);
        collect_tx(1, "post_reset_tx");
        n_assert++;
        if (txq.size() != 1 || txq[0] !== 8'h34) begin
            n_fail++; $display("FAIL post_reset_data: bytes=%p, expected 34", txq);
        end
    endtask

    task automatic test_back_to_back;
        int w0 = wr_cnt, e0 = err_cnt;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h22);
        n_assert++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h4, 8'h22}) begin
            n_fail++; $display("FAIL b2b_second: en=%b addr=%h data=%h, expected 1 4 22", rf_wr_en, rf_addr, rf_wr_data);
        end
        cycles(2);
        n_assert++;
        if (wr_cnt != w0 + 2 || rf_m[3] !== 8'h11 || rf_m[4] !== 8'h22 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL b2b_effect: writes=%0d rf3=%h rf4=%h err=%0d, expected 2 11 22 0", wr_cnt - w0, rf_m[3], rf_m[4], err_cnt - e0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_write();
        test_read_hold();
        test_alu_cc();
        test_bad_fun();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command sequencer for the UART system: it parses byte frames from the UART receiver and drives the register file and the ALU. It returns read data and ALU results, two bytes LSB first, to the UART transmitter. It sits between the RX/TX byte streams and the RF/ALU datapath. It is the only master of the RF write/read ports and of the ALU enable/function inputs.

## Interface
- DATA_W, 8, RF word and UART byte width
- ADDR_W, 4, RF address width; address taken from rx_data[ADDR_W-1:0]
- TIMEOUT, 1024, max idle cycles between bytes of one frame before abort
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- rx_data  in  DATA_W  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rf_wr_en  out  1  one-cycle RF write strobe
- rf_rd_en  out  1  one-cycle RF read strobe
- rf_addr  out  ADDR_W  RF address
- rf_wr_data  out  DATA_W  RF write data
- rf_rd_data  in  DATA_W  RF read data
- rf_rd_valid  in  1  rf_rd_data valid (pulse)
- alu_en  out  1  one-cycle ALU start strobe
- alu_fun  out  4  ALU opcode, alu_pkg::alu_op_e encoding (ADD=0 … SHL=0xE)
- alu_out  in  2*DATA_W  ALU result
- alu_out_valid  in  1  alu_out valid (pulse)
- tx_data  out  DATA_W  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready
- err  out  1  one-cycle pulse on frame error/abort

## Operation
- Frames, first byte = command:
  - 0xAA: addr, data. Write RF[addr] = data. No response.
  - 0xBB: addr. Read RF[addr]. Send 1 byte.
  - 0xCC: A, B, fun. Write RF[0]=A and RF[1]=B. Run ALU with fun. Send 2 bytes, alu_out[7:0] then alu_out[15:8].
  - 0xDD: fun. Run ALU on current RF[0]/RF[1]. Send 2 bytes as for 0xCC.
- Any other command byte in IDLE: ignored, err pulses, stay IDLE.
- fun uses rx_data[3:0]; rx_data[7:4] is ignored.
  - fun == 4'hF (undefined opcode): no ALU start, err pulses, return to IDLE, no response.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_B0, TX_B1.
  - IDLE → WR_ADDR (0xAA) / RD_ADDR (0xBB) / ALU_A (0xCC) / ALU_FUN (0xDD).
  - WR_ADDR → WR_DATA → IDLE.
  - RD_ADDR → RD_WAIT → TX_B0 → IDLE.
  - ALU_A → ALU_B → ALU_FUN → ALU_WAIT → TX_B0 → TX_B1 → IDLE.
- rx_valid in RD_WAIT, ALU_WAIT, TX_B0, TX_B1: byte dropped silently.
- Inter-byte timeout:
  - A counter resets on every accepted rx_valid in WR_*, RD_ADDR, ALU_A/B/FUN.
  - It reaches TIMEOUT cycles: err pulses, state → IDLE, no RF/ALU strobe.
  - The timeout does not apply in wait or TX states.
- Responses are captured in internal registers. tx_data comes from the capture, never combinationally from rf_rd_data/alu_out.

## Timing
- Reset values: rf_wr_en=0, rf_rd_en=0, rf_addr=0, rf_wr_data=0, alu_en=0, alu_fun=0, tx_data=0, tx_valid=0, err=0, state=IDLE, timeout counter=0.
- rst_n asserted mid-frame: frame discarded, all outputs return to reset values immediately (async).
- All outputs are registered.
- rf_wr_en is high exactly one cycle, the cycle after the rx_valid of the data byte (0xAA) or of the A/B byte (0xCC).
  - rf_addr/rf_wr_data are valid in that same cycle.
  - For 0xCC: rf_addr=0 for A, 1 for B.
- rf_rd_en pulses the cycle after the address rx_valid.
  - rf_rd_data is captured on rf_rd_valid.
  - tx_valid rises the following cycle.
- alu_en pulses the cycle after the fun rx_valid, with alu_fun valid in that cycle and held until the next ALU command.
  - alu_out is captured on alu_out_valid.
  - tx_valid rises the next cycle.
- TX handshake:
  - tx_valid/tx_data hold until the cycle with tx_ready=1.
  - Byte 1 of a 2-byte response is presented the cycle after byte 0 is accepted.
  - tx_valid falls the cycle after the final byte is accepted.
- Earliest re-entry: the IDLE state accepts a new command byte the cycle after returning.
- Timeout and rx_valid in the same cycle: rx_valid wins, counter resets.

## Test plan
- 0xAA,0x05,0x3C → one rf_wr_en with rf_addr=5, rf_wr_data=0x3C; no tx_valid.
- 0xBB,0x05, RF returns 0x3C after 2 cycles → rf_rd_en with rf_addr=5; tx_data=0x3C held through 3 cycles of tx_ready=0, accepted once.
- 0xCC,0x12,0x34,0x02 (MUL), alu_out=0x03A8 → RF[0]=0x12, RF[1]=0x34 writes; alu_en with alu_fun=2; tx bytes 0xA8 then 0x03.
- 0xDD,0x0F → no alu_en, err pulse, IDLE; then 0xDD,0x00 with alu_out=0x0046 → tx 0x46,0x00.
- 0xAA,0x05 then no byte for TIMEOUT cycles → err pulse, no rf_wr_en; the next 0x77 alone → err, no strobes.
- rst_n low during ALU_WAIT with tx pending → all outputs 0; after release, 0xBB,0x01 completes normally.
